// File: rtl/axi_lite_req_arbiter.sv
// axi_lite_req_arbiter
// Shares one AXI-Lite master among N_REQ requesters. Requesters are picked
// round-robin and only one command is in flight at a time. The block pulses
// the master's write or read start, then watches the B or R handshake for
// completion. It returns a one-cycle response tagged with the requester ID.
// A WAIT timeout guards against a slave that never answers.
module axi_lite_req_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = $clog2(N_REQ),
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [N_REQ-1:0]    REQ_VALID,
  input  logic [N_REQ-1:0]    REQ_WR,
  input  logic [N_REQ*32-1:0] REQ_ADDR,
  input  logic [N_REQ*32-1:0] REQ_WDATA,
  input  logic [N_REQ*4-1:0]  REQ_STRB,
  output logic [N_REQ-1:0]    REQ_READY,
  output logic                RSP_VALID,
  output logic [ID_W-1:0]     RSP_ID,
  output logic [1:0]          RSP_RESP,
  output logic [31:0]         RSP_RDATA,
  output logic [31:0]         C_ADRR,
  output logic [31:0]         C_DATA,
  output logic [3:0]          C_STRB,
  output logic                C_VALID,
  output logic [31:0]         C_ADRR_R,
  output logic                C_VALID_R,
  input  logic                M_BVALID,
  input  logic                M_BREADY,
  input  logic [1:0]          M_BRESP,
  input  logic                M_RDONE,
  input  logic [31:0]         M_RDATA,
  output logic                TIMEOUT_ERR
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    WAIT  = 4'b0100,
    RESP  = 4'b1000
  } state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [31:0]      c_adrr_q, c_adrr_d;
  logic [31:0]      c_data_q, c_data_d;
  logic [3:0]       c_strb_q, c_strb_d;
  logic [31:0]      c_adrr_r_q, c_adrr_r_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [1:0]       rsp_resp_q, rsp_resp_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             timeout_err_q, timeout_err_d;

  // Per-requester views of the packed command buses, plus the search order
  // starting at the round-robin pointer.
  logic [31:0]     req_addr  [N_REQ];
  logic [31:0]     req_wdata [N_REQ];
  logic [3:0]      req_strb  [N_REQ];
  logic [ID_W-1:0] cand_idx  [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign req_addr[gi]  = REQ_ADDR[32*gi +: 32];
    assign req_wdata[gi] = REQ_WDATA[32*gi +: 32];
    assign req_strb[gi]  = REQ_STRB[4*gi +: 4];
    assign cand_idx[gi]  = ID_W'((int'(ptr_q) + gi) % N_REQ);
  end

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;

  // Pick the first valid requester at or after the pointer, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (REQ_VALID[cand_idx[k]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  // Accept is only offered while idle; at most one bit is set.
  always_comb begin
    REQ_READY = '0;
    if (state_q == IDLE && grant_found) begin
      REQ_READY[grant_idx] = 1'b1;
    end
  end

  // Next-state logic: sequence the command and capture the response.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    wr_d          = wr_q;
    id_d          = id_q;
    c_adrr_d      = c_adrr_q;
    c_data_d      = c_data_q;
    c_strb_d      = c_strb_q;
    c_adrr_r_d    = c_adrr_r_q;
    rsp_id_d      = rsp_id_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_rdata_d   = rsp_rdata_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d = ISSUE;
          wr_d    = REQ_WR[grant_idx];
          id_d    = grant_idx;
          ptr_d   = (grant_idx == ID_LAST) ? '0 : grant_idx + 1'b1;
          if (REQ_WR[grant_idx]) begin
            c_adrr_d = req_addr[grant_idx];
            c_data_d = req_wdata[grant_idx];
            c_strb_d = req_strb[grant_idx];
          end else begin
            c_adrr_r_d = req_addr[grant_idx];
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Completion is tested before the timeout so it wins on the last count.
        if (wr_q && M_BVALID && M_BREADY) begin
          state_d     = RESP;
          rsp_id_d    = id_q;
          rsp_resp_d  = M_BRESP;
          rsp_rdata_d = '0;
        end else if (!wr_q && M_RDONE) begin
          state_d     = RESP;
          rsp_id_d    = id_q;
          rsp_resp_d  = 2'b00;
          rsp_rdata_d = M_RDATA;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = RESP;
          rsp_id_d      = id_q;
          rsp_resp_d    = 2'b10;
          rsp_rdata_d   = '0;
          timeout_err_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any outstanding command.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      wr_q          <= 1'b0;
      id_q          <= '0;
      c_adrr_q      <= '0;
      c_data_q      <= '0;
      c_strb_q      <= '0;
      c_adrr_r_q    <= '0;
      rsp_id_q      <= '0;
      rsp_resp_q    <= '0;
      rsp_rdata_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      wr_q          <= wr_d;
      id_q          <= id_d;
      c_adrr_q      <= c_adrr_d;
      c_data_q      <= c_data_d;
      c_strb_q      <= c_strb_d;
      c_adrr_r_q    <= c_adrr_r_d;
      rsp_id_q      <= rsp_id_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_rdata_q   <= rsp_rdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign C_VALID     = (state_q == ISSUE) && wr_q;
  assign C_VALID_R   = (state_q == ISSUE) && !wr_q;
  assign RSP_VALID   = (state_q == RESP);
  assign C_ADRR      = c_adrr_q;
  assign C_DATA      = c_data_q;
  assign C_STRB      = c_strb_q;
  assign C_ADRR_R    = c_adrr_r_q;
  assign RSP_ID      = rsp_id_q;
  assign RSP_RESP    = rsp_resp_q;
  assign RSP_RDATA   = rsp_rdata_q;
  assign TIMEOUT_ERR = timeout_err_q;

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Bench for axi_lite_req_arbiter. It checks the DUT against a
// transaction-level model kept as cycle numbers: when the command was
// accepted, and when it completed or timed out. Directed scenarios come
// first, then randomized traffic.
module tb_axi_lite_req_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TC = 8;

  logic            ACLK = 1'b0;
  logic            ARESET = 1'b1;
  logic [N-1:0]    REQ_VALID = '0;
  logic [N-1:0]    REQ_WR = '0;
  logic [N*32-1:0] REQ_ADDR = '0;
  logic [N*32-1:0] REQ_WDATA = '0;
  logic [N*4-1:0]  REQ_STRB = '0;
  logic [N-1:0]    REQ_READY;
  logic            RSP_VALID;
  logic [IW-1:0]   RSP_ID;
  logic [1:0]      RSP_RESP;
  logic [31:0]     RSP_RDATA;
  logic [31:0]     C_ADRR, C_DATA, C_ADRR_R;
  logic [3:0]      C_STRB;
  logic            C_VALID, C_VALID_R;
  logic            M_BVALID = 1'b0, M_BREADY = 1'b0, M_RDONE = 1'b0;
  logic [1:0]      M_BRESP = '0;
  logic [31:0]     M_RDATA = '0;
  logic            TIMEOUT_ERR;

  axi_lite_req_arbiter #(.N_REQ(N), .ID_W(IW), .TIMEOUT_CYC(TC)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .REQ_VALID(REQ_VALID), .REQ_WR(REQ_WR), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_STRB(REQ_STRB), .REQ_READY(REQ_READY),
    .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_RESP(RSP_RESP), .RSP_RDATA(RSP_RDATA),
    .C_ADRR(C_ADRR), .C_DATA(C_DATA), .C_STRB(C_STRB), .C_VALID(C_VALID),
    .C_ADRR_R(C_ADRR_R), .C_VALID_R(C_VALID_R),
    .M_BVALID(M_BVALID), .M_BREADY(M_BREADY), .M_BRESP(M_BRESP),
    .M_RDONE(M_RDONE), .M_RDATA(M_RDATA), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 ACLK = ~ACLK;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Requester-side pending commands, held until the model says accepted.
  logic        pend_v    [N];
  logic        pend_wr   [N];
  logic [31:0] pend_addr [N];
  logic [31:0] pend_data [N];
  logic [3:0]  pend_strb [N];
  bit          refill_hold = 1'b0;
  bit          rand_arrivals = 1'b0;
  int          force_d = -1;
  bit          force_vals = 1'b0;
  logic [1:0]  force_bresp = '0;
  logic [31:0] force_rdata = '0;
  bit          rst_drv = 1'b1;

  // Model: one outstanding transaction described by cycle numbers.
  bit          m_busy;
  int          m_t, m_end, m_plan, m_ptr, m_id;
  logic        m_wr;
  logic [31:0] m_c_adrr, m_c_data, m_c_adrr_r;
  logic [3:0]  m_c_strb;
  int          m_rsp_id;
  logic [1:0]  m_rsp_resp;
  logic [31:0] m_rsp_rdata;
  logic        m_terr;

  // Observations of the DUT used by the literal expectations.
  int          obs_cv_cyc, obs_cvr_cyc, obs_rsp_cyc;
  logic [31:0] obs_cv_addr, obs_cv_data, obs_cvr_addr;
  logic [3:0]  obs_cv_strb;
  int          obs_grants [$];
  int          exp_order [6] = '{0, 1, 2, 3, 0, 1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_t = -100; m_end = -1; m_plan = 0; m_ptr = 0; m_id = 0; m_wr = 1'b0;
    m_c_adrr = '0; m_c_data = '0; m_c_strb = '0; m_c_adrr_r = '0;
    m_rsp_id = 0; m_rsp_resp = '0; m_rsp_rdata = '0; m_terr = 1'b0;
  endtask

  task automatic obs_reset();
    obs_cv_cyc = -1; obs_cvr_cyc = -1; obs_rsp_cyc = -1;
    obs_cv_addr = '0; obs_cv_data = '0; obs_cvr_addr = '0; obs_cv_strb = '0;
    obs_grants.delete();
  endtask

  task automatic new_cmd(input int i);
    pend_v[i] = 1'b1; pend_wr[i] = 1'($urandom_range(0, 1));
    pend_addr[i] = $urandom; pend_data[i] = $urandom; pend_strb[i] = 4'($urandom);
  endtask

  task automatic set_cmd(input int i, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    pend_v[i] = 1'b1; pend_wr[i] = wr; pend_addr[i] = a; pend_data[i] = d; pend_strb[i] = s;
  endtask

  // One clock cycle: drive inputs, compare every output with the model, advance the model.
  task automatic step();
    logic [N-1:0] v;
    logic [N-1:0] exp_ready;
    bit in_wait, hs_now;
    int g;
    @(negedge ACLK);
    for (int i = 0; i < N; i++) begin
      v[i] = pend_v[i];
      REQ_WR[i] = pend_wr[i];
      REQ_ADDR[32*i +: 32] = pend_addr[i];
      REQ_WDATA[32*i +: 32] = pend_data[i];
      REQ_STRB[4*i +: 4] = pend_strb[i];
    end
    REQ_VALID = v;
    ARESET = rst_drv;
    in_wait = m_busy && m_end < 0 && cyc >= m_t + 2;
    hs_now = in_wait && (cyc == m_t + 2 + m_plan);
    M_BRESP = 2'($urandom);
    M_RDATA = $urandom;
    if (hs_now && force_vals) begin
      M_BRESP = force_bresp;
      M_RDATA = force_rdata;
    end
    if (in_wait && m_wr) begin
      M_RDONE = ($urandom_range(0, 3) == 0);
      if (hs_now) begin
        M_BVALID = 1'b1; M_BREADY = 1'b1;
      end else begin
        M_BVALID = 1'($urandom_range(0, 1));
        M_BREADY = !M_BVALID && ($urandom_range(0, 1) == 1);
      end
    end else if (in_wait) begin
      M_BVALID = 1'($urandom_range(0, 1));
      M_BREADY = 1'($urandom_range(0, 1));
      M_RDONE = hs_now;
    end else begin
      M_BVALID = ($urandom_range(0, 3) == 0);
      M_BREADY = 1'($urandom_range(0, 1));
      M_RDONE = ($urandom_range(0, 3) == 0);
    end
    #1;
    g = rr_pick(v, m_ptr);
    exp_ready = '0;
    if (!m_busy && g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", REQ_READY, exp_ready);
    chk("c_valid", C_VALID, m_busy && m_wr && cyc == m_t + 1);
    chk("c_valid_r", C_VALID_R, m_busy && !m_wr && cyc == m_t + 1);
    chk("rsp_valid", RSP_VALID, m_busy && m_end >= 0 && cyc == m_end + 1);
    chk("rsp_id", RSP_ID, m_rsp_id);
    chk("rsp_resp", RSP_RESP, m_rsp_resp);
    chk("rsp_rdata", RSP_RDATA, m_rsp_rdata);
    chk("timeout_err", TIMEOUT_ERR, m_terr);
    if (m_busy && m_wr) begin
      chk("c_adrr", C_ADRR, m_c_adrr);
      chk("c_data", C_DATA, m_c_data);
      chk("c_strb", C_STRB, m_c_strb);
    end
    if (m_busy && !m_wr) chk("c_adrr_r", C_ADRR_R, m_c_adrr_r);
    if (C_VALID === 1'b1) begin
      obs_cv_cyc = cyc; obs_cv_addr = C_ADRR; obs_cv_data = C_DATA; obs_cv_strb = C_STRB;
    end
    if (C_VALID_R === 1'b1) begin
      obs_cvr_cyc = cyc; obs_cvr_addr = C_ADRR_R;
    end
    if (RSP_VALID === 1'b1) obs_rsp_cyc = cyc;
    for (int i = 0; i < N; i++) if (REQ_READY[i] === 1'b1) obs_grants.push_back(i);
    // Advance the model across the coming rising edge.
    if (rst_drv) begin
      model_reset();
    end else if (m_busy) begin
      if (in_wait) begin
        if (m_wr ? (M_BVALID && M_BREADY) : M_RDONE) begin
          m_end = cyc; m_rsp_id = m_id;
          m_rsp_resp = m_wr ? M_BRESP : 2'b00;
          m_rsp_rdata = m_wr ? 32'h0 : M_RDATA;
        end else if (cyc == m_t + TC + 1) begin
          m_end = cyc; m_rsp_id = m_id; m_rsp_resp = 2'b10; m_rsp_rdata = '0; m_terr = 1'b1;
        end
      end else if (m_end >= 0 && cyc == m_end + 1) begin
        m_busy = 1'b0;
        $display("txn id=%0d %s resp=%0d rdata=%08h accepted@%0d responded@%0d",
                 m_rsp_id, m_wr ? "WR" : "RD", m_rsp_resp, m_rsp_rdata, m_t, cyc);
      end
    end else if (g >= 0) begin
      m_busy = 1'b1; m_t = cyc; m_end = -1; m_ptr = (g + 1) % N;
      m_wr = pend_wr[g]; m_id = g;
      if (m_wr) begin
        m_c_adrr = pend_addr[g]; m_c_data = pend_data[g]; m_c_strb = pend_strb[g];
      end else begin
        m_c_adrr_r = pend_addr[g];
      end
      m_plan = (force_d >= 0) ? force_d : int'($urandom_range(0, TC + 1));
      if (refill_hold) new_cmd(g);
      else pend_v[g] = 1'b0;
    end
    if (rand_arrivals) begin
      for (int i = 0; i < N; i++) if (!pend_v[i] && $urandom_range(0, 3) == 0) new_cmd(i);
    end
    cyc++;
  endtask

  task automatic reset_dut();
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    rst_drv = 1'b1;
    step();
    rst_drv = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, REQ_READY, 0);
    chk({tag, "_rsp_valid"}, RSP_VALID, 0);
    chk({tag, "_c_valid"}, C_VALID, 0);
    chk({tag, "_c_valid_r"}, C_VALID_R, 0);
    chk({tag, "_timeout_err"}, TIMEOUT_ERR, 0);
    chk({tag, "_rsp_id"}, RSP_ID, 0);
    chk({tag, "_rsp_resp"}, RSP_RESP, 0);
    chk({tag, "_rsp_rdata"}, RSP_RDATA, 0);
    chk({tag, "_c_adrr"}, C_ADRR, 0);
    chk({tag, "_c_data"}, C_DATA, 0);
    chk({tag, "_c_strb"}, C_STRB, 0);
    chk({tag, "_c_adrr_r"}, C_ADRR_R, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b0; pend_wr[i] = 1'b0; pend_addr[i] = '0; pend_data[i] = '0; pend_strb[i] = '0;
    end
    model_reset();
    obs_reset();

    // Reset values
    rst_drv = 1'b1;
    step();
    step();
    chk_reset_outputs("rst");
    rst_drv = 1'b0;

    // Single write from requester 1, B handshake three cycles after ISSUE
    obs_reset();
    force_d = 2; force_vals = 1'b1; force_bresp = 2'b00; force_rdata = '0;
    set_cmd(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    repeat (10) step();
    chk("wr_c_adrr", obs_cv_addr, 32'h10);
    chk("wr_c_data", obs_cv_data, 32'hDEADBEEF);
    chk("wr_c_strb", obs_cv_strb, 4'hF);
    chk("wr_issue_to_rsp", obs_rsp_cyc - obs_cv_cyc, 4);
    chk("wr_rsp_id", RSP_ID, 1);
    chk("wr_rsp_resp", RSP_RESP, 2'b00);

    // Single read from requester 2
    obs_reset();
    force_d = 1; force_rdata = 32'h12345678;
    set_cmd(2, 1'b0, 32'h20, 32'h0, 4'h0);
    repeat (10) step();
    chk("rd_c_adrr_r", obs_cvr_addr, 32'h20);
    chk("rd_issue_to_rsp", obs_rsp_cyc - obs_cvr_cyc, 3);
    chk("rd_rsp_id", RSP_ID, 2);
    chk("rd_rsp_rdata", RSP_RDATA, 32'h12345678);
    chk("rd_rsp_resp", RSP_RESP, 2'b00);

    // Contention: all requesters valid from reset
    reset_dut();
    obs_reset();
    force_d = 0; force_vals = 1'b0;
    for (int i = 0; i < N; i++) new_cmd(i);
    refill_hold = 1'b1;
    repeat (26) step();
    refill_hold = 1'b0;
    chk("cont_grant_count_ok", obs_grants.size() >= 6, 1);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("cont_grant%0d", k), (k < obs_grants.size()) ? obs_grants[k] : -1, exp_order[k]);
    end

    // Completion landing exactly on the last WAIT count
    reset_dut();
    obs_reset();
    force_d = TC - 1; force_vals = 1'b1; force_bresp = 2'b01;
    set_cmd(1, 1'b1, 32'h40, 32'h55AA55AA, 4'h3);
    repeat (16) step();
    chk("edge_issue_to_rsp", obs_rsp_cyc - obs_cv_cyc, TC + 1);
    chk("edge_rsp_resp", RSP_RESP, 2'b01);
    chk("edge_timeout_err", TIMEOUT_ERR, 0);

    // Timeout: write with no B handshake
    reset_dut();
    obs_reset();
    force_d = 99;
    set_cmd(0, 1'b1, 32'h50, 32'h11112222, 4'hC);
    repeat (16) step();
    chk("to_issue_to_rsp", obs_rsp_cyc - obs_cv_cyc, 9);
    chk("to_rsp_resp", RSP_RESP, 2'b10);
    chk("to_rsp_rdata", RSP_RDATA, 0);
    chk("to_timeout_err", TIMEOUT_ERR, 1);
    obs_reset();
    force_d = 1; force_bresp = 2'b00;
    set_cmd(3, 1'b1, 32'h54, 32'h33334444, 4'hF);
    repeat (10) step();
    chk("to_next_rsp_seen", obs_rsp_cyc >= 0, 1);
    chk("to_next_rsp_id", RSP_ID, 3);
    chk("to_next_rsp_resp", RSP_RESP, 2'b00);
    chk("to_sticky", TIMEOUT_ERR, 1);

    // Reset while in WAIT
    reset_dut();
    obs_reset();
    force_d = 99;
    set_cmd(2, 1'b1, 32'h60, 32'h77778888, 4'hF);
    repeat (5) step();
    rst_drv = 1'b1;
    step();
    rst_drv = 1'b0;
    step();
    chk_reset_outputs("mid");
    repeat (12) step();
    chk("mid_no_rsp", obs_rsp_cyc, -1);
    obs_reset();
    force_d = 1; force_rdata = 32'hCAFEF00D;
    set_cmd(3, 1'b0, 32'h70, 32'h0, 4'h0);
    repeat (8) step();
    chk("mid_next_grant", (obs_grants.size() > 0) ? obs_grants[0] : -1, 3);
    chk("mid_next_c_adrr_r", obs_cvr_addr, 32'h70);
    chk("mid_next_rsp_id", RSP_ID, 3);
    chk("mid_next_rsp_rdata", RSP_RDATA, 32'hCAFEF00D);

    // Randomized traffic
    reset_dut();
    force_d = -1; force_vals = 1'b0;
    rand_arrivals = 1'b1;
    repeat (1500) step();
    rand_arrivals = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
